// File: rtl/eth_pkg.sv
// Shared types and constants for the Ethernet stream transmit scheduler.
package eth_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_HDR,
    ST_PAY,
    ST_WAIT_DONE
  } tx_state_t;

  localparam logic STREAM_VOICE = 1'b0;
  localparam logic STREAM_VIDEO = 1'b1;

  localparam logic [7:0]  HDR_MAGIC = 8'hA5;
  localparam int unsigned HDR_WORDS = 2;

  // UDP payload length in bytes for a packet of pkt_words 16-bit payload words.
  function automatic logic [15:0] udp_len_bytes(input int unsigned pkt_words);
    return 16'((pkt_words + HDR_WORDS) * 2);
  endfunction

endpackage

// File: rtl/eth_tx_rr_arb.sv
// Stream arbiter: eligibility, voice priority with a bounded voice run while video waits.
module eth_tx_rr_arb
  import eth_pkg::*;
#(
  parameter int unsigned VOICE_PKT_WORDS = 256,
  parameter int unsigned VIDEO_PKT_WORDS = 512,
  parameter int unsigned MAX_VOICE_RUN   = 4,
  parameter int unsigned CNT_W           = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] voice_fifo_cnt,
  input  logic [CNT_W-1:0] video_fifo_cnt,
  input  logic             grant_en,
  output logic             grant_valid,
  output logic             grant_sel
);

  localparam int unsigned RUN_W = $clog2(MAX_VOICE_RUN + 2);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(MAX_VOICE_RUN);
  localparam logic [CNT_W-1:0] VOICE_TH = CNT_W'(VOICE_PKT_WORDS);
  localparam logic [CNT_W-1:0] VIDEO_TH = CNT_W'(VIDEO_PKT_WORDS);

  logic             voice_ok;
  logic             video_ok;
  logic [RUN_W-1:0] run_cnt;

  // Grant decision: voice first unless the voice run limit has been reached.
  always_comb begin
    voice_ok    = (voice_fifo_cnt >= VOICE_TH);
    video_ok    = (video_fifo_cnt >= VIDEO_TH);
    grant_valid = voice_ok | video_ok;
    grant_sel   = STREAM_VOICE;
    if (video_ok && (!voice_ok || run_cnt == RUN_MAX))
      grant_sel = STREAM_VIDEO;
  end

  // Run counter: counts voice grants that passed over an eligible video stream.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_cnt <= '0;
    end else if (grant_en && grant_valid) begin
      if (grant_sel == STREAM_VOICE && video_ok)
        run_cnt <= run_cnt + 1'b1;
      else
        run_cnt <= '0;
    end
  end

endmodule

// File: rtl/eth_stream_tx_sched.sv
// Shares one UDP transmit engine between the voice and video FIFOs:
// picks a stream, requests a frame, then serves header and payload words.
module eth_stream_tx_sched
  import eth_pkg::*;
#(
  parameter int unsigned VOICE_PKT_WORDS = 256,
  parameter int unsigned VIDEO_PKT_WORDS = 512,
  parameter int unsigned MAX_VOICE_RUN   = 4,
  parameter int unsigned ACK_TIMEOUT     = 4096,
  parameter int unsigned CNT_W           = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [CNT_W-1:0] voice_fifo_cnt,
  input  logic [15:0]      voice_rd_data,
  output logic             voice_rd_en,
  input  logic [CNT_W-1:0] video_fifo_cnt,
  input  logic [15:0]      video_rd_data,
  output logic             video_rd_en,
  output logic             udp_tx_req,
  output logic [15:0]      udp_tx_len,
  input  logic             udp_tx_ack,
  input  logic             udp_data_req,
  output logic [15:0]      udp_tx_data,
  input  logic             udp_tx_done,
  output logic             stream_sel,
  output logic [7:0]       drop_cnt
);

  localparam int unsigned TMR_W = $clog2(ACK_TIMEOUT + 1);
  localparam logic [TMR_W-1:0] TMR_LAST   = TMR_W'(ACK_TIMEOUT - 1);
  localparam logic [15:0]      VOICE_LAST = 16'(VOICE_PKT_WORDS + HDR_WORDS - 1);
  localparam logic [15:0]      VIDEO_LAST = 16'(VIDEO_PKT_WORDS + HDR_WORDS - 1);
  localparam logic [15:0]      HDR_LAST   = 16'(HDR_WORDS - 1);
  localparam logic [15:0]      VOICE_LEN  = udp_len_bytes(VOICE_PKT_WORDS);
  localparam logic [15:0]      VIDEO_LEN  = udp_len_bytes(VIDEO_PKT_WORDS);

  tx_state_t        state;
  tx_state_t        state_nxt;
  logic             grant_valid;
  logic             grant_sel;
  logic [TMR_W-1:0] tmr;
  logic [15:0]      word_cnt;
  logic [15:0]      word_last;
  logic [15:0]      seq_voice;
  logic [15:0]      seq_video;
  logic [15:0]      seq_cur;
  logic [15:0]      hdr_q;
  logic             pay_q;
  logic             serving;
  logic             timeout;

  eth_tx_rr_arb #(
    .VOICE_PKT_WORDS(VOICE_PKT_WORDS),
    .VIDEO_PKT_WORDS(VIDEO_PKT_WORDS),
    .MAX_VOICE_RUN  (MAX_VOICE_RUN),
    .CNT_W          (CNT_W)
  ) u_arb (
    .clk           (clk),
    .rst           (rst),
    .voice_fifo_cnt(voice_fifo_cnt),
    .video_fifo_cnt(video_fifo_cnt),
    .grant_en      (state == ST_IDLE),
    .grant_valid   (grant_valid),
    .grant_sel     (grant_sel)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic and combinational outputs (FIFO pops, request, data mux).
  always_comb begin
    state_nxt   = state;
    serving     = (state == ST_HDR) || (state == ST_PAY);
    word_last   = stream_sel ? VIDEO_LAST : VOICE_LAST;
    seq_cur     = stream_sel ? seq_video : seq_voice;
    timeout     = (state == ST_REQ) && !udp_tx_ack && (tmr == TMR_LAST);
    udp_tx_req  = (state == ST_REQ);
    voice_rd_en = (state == ST_PAY) && udp_data_req && (stream_sel == STREAM_VOICE);
    video_rd_en = (state == ST_PAY) && udp_data_req && (stream_sel == STREAM_VIDEO);
    // Payload words come straight from the FIFO read port, which lags rd_en by
    // one clk; header words are registered so both arrive on the same cycle.
    udp_tx_data = pay_q ? (stream_sel ? video_rd_data : voice_rd_data) : hdr_q;
    case (state)
      ST_IDLE:      if (grant_valid) state_nxt = ST_REQ;
      ST_REQ:       if (udp_tx_ack) state_nxt = ST_HDR;
                    else if (timeout) state_nxt = ST_IDLE;
      ST_HDR:       if (udp_data_req && word_cnt == HDR_LAST) state_nxt = ST_PAY;
      ST_PAY:       if (udp_data_req && word_cnt == word_last) state_nxt = ST_WAIT_DONE;
      ST_WAIT_DONE: if (udp_tx_done) state_nxt = ST_IDLE;
      default:      state_nxt = ST_IDLE;
    endcase
  end

  // Grant latch, ack timer, word counter and drop counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stream_sel <= STREAM_VOICE;
      udp_tx_len <= '0;
      tmr        <= '0;
      word_cnt   <= '0;
      drop_cnt   <= '0;
    end else begin
      if (state == ST_IDLE && grant_valid) begin
        stream_sel <= grant_sel;
        udp_tx_len <= grant_sel ? VIDEO_LEN : VOICE_LEN;
      end
      tmr <= (state == ST_REQ) ? tmr + 1'b1 : '0;
      if (!serving)
        word_cnt <= '0;
      else if (udp_data_req)
        word_cnt <= word_cnt + 1'b1;
      if (timeout && drop_cnt != 8'hFF)
        drop_cnt <= drop_cnt + 1'b1;
    end
  end

  // Per-stream sequence numbers, advanced once the engine reports the frame sent.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seq_voice <= '0;
      seq_video <= '0;
    end else if (state == ST_WAIT_DONE && udp_tx_done) begin
      if (stream_sel == STREAM_VIDEO) seq_video <= seq_video + 1'b1;
      else                            seq_voice <= seq_voice + 1'b1;
    end
  end

  // Header word register and payload-select flag for the word due next clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hdr_q <= '0;
      pay_q <= 1'b0;
    end else begin
      hdr_q <= '0;
      pay_q <= (state == ST_PAY) && udp_data_req;
      if (state == ST_HDR && udp_data_req)
        hdr_q <= (word_cnt == '0) ? {HDR_MAGIC, 7'd0, stream_sel} : seq_cur;
    end
  end

endmodule

// File: tb/tb_eth_stream_tx_sched.sv
// Directed bench for eth_stream_tx_sched with a simple FIFO read-port model.
module tb_eth_stream_tx_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [11:0] voice_fifo_cnt = '0;
  logic [15:0] voice_rd_data = '0;
  logic        voice_rd_en;
  logic [11:0] video_fifo_cnt = '0;
  logic [15:0] video_rd_data = '0;
  logic        video_rd_en;
  logic        udp_tx_req;
  logic [15:0] udp_tx_len;
  logic        udp_tx_ack = 1'b0;
  logic        udp_data_req = 1'b0;
  logic [15:0] udp_tx_data;
  logic        udp_tx_done = 1'b0;
  logic        stream_sel;
  logic [7:0]  drop_cnt;

  int unsigned n_err = 0;
  int unsigned n_chk = 0;

  // FIFO models: sequential data, one clk read latency.
  logic [15:0] v_mem_next = 16'h1000;
  logic [15:0] d_mem_next = 16'h8000;
  int unsigned voice_pops = 0;
  int unsigned video_pops = 0;
  logic [15:0] exp_v = 16'h1000;
  logic [15:0] exp_d = 16'h8000;

  eth_stream_tx_sched #(
    .VOICE_PKT_WORDS(256),
    .VIDEO_PKT_WORDS(512),
    .MAX_VOICE_RUN  (4),
    .ACK_TIMEOUT    (4096),
    .CNT_W          (12)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .voice_fifo_cnt(voice_fifo_cnt),
    .voice_rd_data (voice_rd_data),
    .voice_rd_en   (voice_rd_en),
    .video_fifo_cnt(video_fifo_cnt),
    .video_rd_data (video_rd_data),
    .video_rd_en   (video_rd_en),
    .udp_tx_req    (udp_tx_req),
    .udp_tx_len    (udp_tx_len),
    .udp_tx_ack    (udp_tx_ack),
    .udp_data_req  (udp_data_req),
    .udp_tx_data   (udp_tx_data),
    .udp_tx_done   (udp_tx_done),
    .stream_sel    (stream_sel),
    .drop_cnt      (drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (voice_rd_en) begin
      voice_rd_data <= v_mem_next;
      v_mem_next    <= v_mem_next + 16'd1;
      voice_pops    <= voice_pops + 1;
    end
    if (video_rd_en) begin
      video_rd_data <= d_mem_next;
      d_mem_next    <= d_mem_next + 16'd1;
      video_pops    <= video_pops + 1;
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_req(output bit ok, output int unsigned waited);
    ok = 1'b0;
    waited = 0;
    for (int i = 0; i < 64; i++) begin
      if (udp_tx_req) begin
        ok = 1'b1;
        return;
      end
      @(negedge clk);
      waited++;
    end
  endtask

  // One complete frame as seen by the engine: request, ack, word service, done.
  task automatic run_frame(input logic exp_sel, input logic [15:0] exp_seq,
                           input int unsigned ack_dly, input bit gaps,
                           input int unsigned extra, input bit last, input bit chk_b2b);
    int unsigned n, tot, got, issued, waited, vp0, dp0;
    bit ok, pending;
    logic [15:0] exp_w;
    n   = exp_sel ? 512 : 256;
    tot = n + 2;
    vp0 = voice_pops;
    dp0 = video_pops;
    wait_req(ok, waited);
    check("req_seen", 32'(ok), 32'd1);
    if (!ok) return;
    if (chk_b2b) check("b2b_gap", waited, 32'd1);
    check("len", 32'(udp_tx_len), exp_sel ? 32'd1028 : 32'd516);
    check("sel", 32'(stream_sel), 32'(exp_sel));
    repeat (ack_dly) @(negedge clk);
    udp_tx_ack = 1'b1;
    if (gaps) udp_data_req = 1'b1;
    @(negedge clk);
    udp_tx_ack   = 1'b0;
    udp_data_req = 1'b0;
    check("req_drop", 32'(udp_tx_req), 32'd0);
    if (gaps) check("ack_req_ign", 32'(udp_tx_data), 32'd0);
    got = 0; issued = 0; pending = 1'b0;
    while (got < tot + extra) begin
      if (pending) begin
        if (got == 0)      exp_w = {8'hA5, 7'd0, exp_sel};
        else if (got == 1) exp_w = exp_seq;
        else if (got < tot) begin
          if (exp_sel) begin exp_w = exp_d; exp_d = exp_d + 16'd1; end
          else         begin exp_w = exp_v; exp_v = exp_v + 16'd1; end
        end else exp_w = 16'h0000;
        check($sformatf("word%0d", got), 32'(udp_tx_data), 32'(exp_w));
        got++;
      end
      if (issued < tot + extra && (!gaps || $urandom_range(0, 2) != 0)) begin
        udp_data_req = 1'b1;
        issued++;
        pending = 1'b1;
      end else begin
        udp_data_req = 1'b0;
        pending = 1'b0;
      end
      @(negedge clk);
    end
    udp_data_req = 1'b0;
    check("voice_pops", voice_pops - vp0, exp_sel ? 32'd0 : n);
    check("video_pops", video_pops - dp0, exp_sel ? n : 32'd0);
    if (last) begin
      voice_fifo_cnt = '0;
      video_fifo_cnt = '0;
    end
    udp_tx_done = 1'b1;
    @(negedge clk);
    udp_tx_done = 1'b0;
  endtask

  initial begin
    bit ok;
    int unsigned waited, hi, vp0;
    logic [15:0] seq_v, seq_d;
    logic pat [10];
    pat = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_req", 32'(udp_tx_req), 32'd0);
    check("rst_len", 32'(udp_tx_len), 32'd0);
    check("rst_data", 32'(udp_tx_data), 32'd0);
    check("rst_drop", 32'(drop_cnt), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Voice only, ack after 3 clks, continuous data_req
    voice_fifo_cnt = 12'd256;
    run_frame(1'b0, 16'd0, 3, 1'b0, 0, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    check("idle_no_req", 32'(udp_tx_req), 32'd0);

    // Stray done while idle, then gapped data_req with trailing extra requests
    udp_tx_done = 1'b1;
    @(negedge clk);
    udp_tx_done = 1'b0;
    voice_fifo_cnt = 12'd256;
    run_frame(1'b0, 16'd1, 1, 1'b1, 3, 1'b1, 1'b0);

    // Ack timeout, then a normal frame
    repeat (2) @(negedge clk);
    voice_fifo_cnt = 12'd256;
    vp0 = voice_pops;
    wait_req(ok, waited);
    check("to_req_seen", 32'(ok), 32'd1);
    hi = 0;
    while (udp_tx_req && hi < 5000) begin
      hi++;
      @(negedge clk);
    end
    check("to_req_cycles", hi, 32'd4096);
    check("to_drop", 32'(drop_cnt), 32'd1);
    check("to_pops", voice_pops - vp0, 32'd0);
    run_frame(1'b0, 16'd2, 0, 1'b0, 0, 1'b1, 1'b1);
    check("to_drop_keep", 32'(drop_cnt), 32'd1);

    // Sequence wrap
    repeat (3) @(negedge clk);
    force dut.seq_voice = 16'hFFFF;
    @(negedge clk);
    release dut.seq_voice;
    @(negedge clk);
    voice_fifo_cnt = 12'd256;
    run_frame(1'b0, 16'hFFFF, 1, 1'b0, 0, 1'b0, 1'b0);
    run_frame(1'b0, 16'h0000, 1, 1'b0, 0, 1'b1, 1'b1);
    seq_v = 16'd1;
    seq_d = 16'd0;

    // Both streams full: four voice grants, then video
    repeat (2) @(negedge clk);
    voice_fifo_cnt = 12'd256;
    video_fifo_cnt = 12'd512;
    for (int i = 0; i < 10; i++) begin
      if (pat[i]) begin
        run_frame(1'b1, seq_d, 1, 1'b0, 0, i == 9, i != 0);
        seq_d = seq_d + 16'd1;
      end else begin
        run_frame(1'b0, seq_v, 1, 1'b0, 0, 1'b0, i != 0);
        seq_v = seq_v + 16'd1;
      end
    end

    // Reset mid-payload at word 100
    repeat (2) @(negedge clk);
    voice_fifo_cnt = 12'd256;
    wait_req(ok, waited);
    check("rst6_req_seen", 32'(ok), 32'd1);
    udp_tx_ack = 1'b1;
    @(negedge clk);
    udp_tx_ack = 1'b0;
    for (int k = 0; k < 100; k++) begin
      udp_data_req = 1'b1;
      @(negedge clk);
    end
    check("rst6_pay_active", 32'(voice_rd_en), 32'd1);
    rst = 1'b1;
    #1;
    check("rst6_req", 32'(udp_tx_req), 32'd0);
    check("rst6_rd_en", 32'(voice_rd_en), 32'd0);
    check("rst6_data", 32'(udp_tx_data), 32'd0);
    check("rst6_len", 32'(udp_tx_len), 32'd0);
    check("rst6_drop", 32'(drop_cnt), 32'd0);
    exp_v = exp_v + 16'd98;
    udp_data_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    run_frame(1'b0, 16'd0, 2, 1'b0, 0, 1'b1, 1'b0);

    repeat (3) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
